// File: rtl/accumulator_if.sv
// -----------------------------------------------------------------------------
// accumulator_if
//
// Purpose: groups the command/data bus of the two-bank coefficient
// accumulator. The controller (master) drives the enable, the command and the
// write address/data for both banks. The accumulator (slave) returns the read
// stream and its registered state code.
//
// Signals:
//   set        master->slave  block enable (0 forces the FSM to IDLE)
//   cmd[3:0]   master->slave  0 IDLE, 1 LOAD, 2 ACCUMULATE, 3 READ, 4..15 = 0
//   addr_a/b   master->slave  bank-A / bank-B write address (7 bits)
//   data_a/b   master->slave  bank-A / bank-B write data (16 bits)
//   addr_out   slave->master  address of the entry presented during READ
//   data_a_out slave->master  bank-A coefficient at addr_out
//   data_b_out slave->master  bank-B coefficient at addr_out
//   status     slave->master  state code 0 IDLE,1 LOAD,2 ACC,3 READ,4 DONE
//
// Handshake: there is no per-beat valid/ready. A command is accepted on the
// first rising edge where set=1 and the FSM is in IDLE. From then on, every
// edge where status still equals the command and cmd is unchanged is one data
// beat. Changing cmd, or dropping set, ends the operation on that edge and
// returns the FSM to IDLE without performing a beat.
// -----------------------------------------------------------------------------
interface accumulator_if;
    logic        set;
    logic [3:0]  cmd;
    logic [6:0]  addr_a;
    logic [6:0]  addr_b;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [6:0]  addr_out;
    logic [15:0] data_a_out;
    logic [15:0] data_b_out;
    logic [3:0]  status;

    modport master (
        output set, cmd, addr_a, addr_b, data_a, data_b,
        input  addr_out, data_a_out, data_b_out, status
    );

    modport slave (
        input  set, cmd, addr_a, addr_b, data_a, data_b,
        output addr_out, data_a_out, data_b_out, status
    );
endinterface

// File: rtl/accumulator.sv
// -----------------------------------------------------------------------------
// accumulator
//
// Purpose: two-bank (A/B) polynomial coefficient store for the Kyber datapath.
// Each bank has 128 entries of 16 bits. The block loads both banks from a
// producer, adds further coefficient streams into them modulo q = 3329, and
// streams both banks back out in address order.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset (FSM and outputs only; the
//              banks keep their contents)
//   bus    slave modport of accumulator_if (command, write ports, read stream,
//          status)
//
// The status output is the FSM state register itself, so the current state is
// always externally observable.
// -----------------------------------------------------------------------------
module accumulator (
    input  logic          clk,
    input  logic          reset,
    accumulator_if.slave  bus
);

    localparam int          N = 128;
    localparam logic [16:0] Q = 17'd3329;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ACC  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_ACC  = 2'd2,
        CMD_READ = 2'd3
    } cmd_e;

    // Command codes 4..15 behave exactly like IDLE.
    function automatic cmd_e decode_cmd(input logic [3:0] c);
        cmd_e r;
        if (c[3:2] != 2'b00) begin
            r = CMD_IDLE;
        end else begin
            r = cmd_e'(c[1:0]);
        end
        return r;
    endfunction

    // Single conditional subtract. This is exact mod q when both addends are
    // already reduced; otherwise it is only a partial reduction.
    function automatic logic [15:0] red(input logic [16:0] s);
        logic [16:0] t;
        if (s >= Q) begin
            t = s - Q;
        end else begin
            t = s;
        end
        return t[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [15:0] bank_a [N];
    logic [15:0] bank_b [N];

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic [6:0]  k_q,          k_d;
    logic [6:0]  addr_out_q,   addr_out_d;
    logic [15:0] data_a_out_q, data_a_out_d;
    logic [15:0] data_b_out_q, data_b_out_d;

    cmd_e        cmd_eff;
    logic [6:0]  k_next;

    assign cmd_eff = decode_cmd(bus.cmd);
    assign k_next  = k_q + 7'd1;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        // Data outputs are zero outside READ; each branch that stays in or
        // enters READ overrides these defaults.
        addr_out_d   = '0;
        data_a_out_d = '0;
        data_b_out_d = '0;

        if (!bus.set) begin
            state_d = ST_IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (cmd_eff)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_ACC:  state_d = ST_ACC;
                        CMD_READ: begin
                            // Entry 0 appears on the same edge that enters READ.
                            state_d      = ST_READ;
                            k_d          = '0;
                            addr_out_d   = '0;
                            data_a_out_d = bank_a[0];
                            data_b_out_d = bank_b[0];
                        end
                        default:  state_d = ST_IDLE;
                    endcase
                end

                ST_LOAD: begin
                    if (cmd_eff != CMD_LOAD) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_ACC: begin
                    if (cmd_eff != CMD_ACC) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_READ: begin
                    if (cmd_eff != CMD_READ) begin
                        // Abort: the stream stops immediately.
                        state_d = ST_IDLE;
                        k_d     = '0;
                    end else if (k_q == 7'd127) begin
                        state_d = ST_DONE;
                        k_d     = '0;
                    end else begin
                        k_d          = k_next;
                        addr_out_d   = k_next;
                        data_a_out_d = bank_a[k_next];
                        data_b_out_d = bank_b[k_next];
                    end
                end

                ST_DONE: begin
                    if (cmd_eff != CMD_READ) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            addr_out_q   <= '0;
            data_a_out_q <= '0;
            data_b_out_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            addr_out_q   <= addr_out_d;
            data_a_out_q <= data_a_out_d;
            data_b_out_q <= data_b_out_d;
        end
    end

    assign bus.status     = {1'b0, state_q};
    assign bus.addr_out   = addr_out_q;
    assign bus.data_a_out = data_a_out_q;
    assign bus.data_b_out = data_b_out_q;

    // ------------------------------------------------------------------
    // Bank write path
    // ------------------------------------------------------------------
    // The read-modify-write completes within a single cycle. The bank is read
    // combinationally and the reduced sum is written on the same edge. A hit
    // to the same address on the next cycle therefore already reads the
    // updated value, so back-to-back accumulation needs no separate bypass.
    logic        load_we;
    logic        acc_we;
    logic        bank_we;
    logic [15:0] wdata_a;
    logic [15:0] wdata_b;

    assign load_we = bus.set && (state_q == ST_LOAD) && (cmd_eff == CMD_LOAD);
    assign acc_we  = bus.set && (state_q == ST_ACC)  && (cmd_eff == CMD_ACC);
    assign bank_we = load_we || acc_we;

    always_comb begin
        wdata_a = bus.data_a;
        wdata_b = bus.data_b;
        if (acc_we) begin
            wdata_a = red({1'b0, bank_a[bus.addr_a]} + {1'b0, bus.data_a});
            wdata_b = red({1'b0, bank_b[bus.addr_b]} + {1'b0, bus.data_b});
        end
    end

    // The banks have no reset. Gating on reset suppresses a write that lands
    // on the same edge as reset assertion, while the contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && bank_we) begin
            bank_a[bus.addr_a] <= wdata_a;
            bank_b[bus.addr_b] <= wdata_b;
        end
    end

endmodule

// File: tb/tb_accumulator.sv
module tb_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b1;

  accumulator_if bus_if();

  accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] mdl_a [128];
  logic [15:0] mdl_b [128];
  logic [15:0] got_a [128];
  logic [15:0] got_b [128];
  logic [3:0]  mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] c,
                       input logic [6:0] aa, input logic [15:0] da,
                       input logic [6:0] ab, input logic [15:0] db);
    bus_if.set    = s;
    bus_if.cmd    = c;
    bus_if.addr_a = aa;
    bus_if.data_a = da;
    bus_if.addr_b = ab;
    bus_if.data_b = db;
  endtask

  task automatic enter(input logic [3:0] c);
    bus_if.set = 1'b1;
    bus_if.cmd = c;
    tick();
    check("enter_status", {28'd0, bus_if.status}, {28'd0, c});
    mode = c;
  endtask

  task automatic to_idle();
    bus_if.set = 1'b1;
    bus_if.cmd = 4'd0;
    tick();
    check("idle_status", {28'd0, bus_if.status}, 32'd0);
  endtask

  // One LOAD or ACC beat; the model applies it independently of the RTL.
  task automatic write_cycle(input logic [6:0] aa, input logic [15:0] da,
                             input logic [6:0] ab, input logic [15:0] db);
    int ta, tb;
    drive(1'b1, mode, aa, da, ab, db);
    tick();
    check("wr_status", {28'd0, bus_if.status}, {28'd0, mode});
    if (mode == 4'd1) begin
      mdl_a[aa] = da;
      mdl_b[ab] = db;
    end else begin
      ta = (int'(mdl_a[aa]) + int'(da)) % 3329;
      tb = (int'(mdl_b[ab]) + int'(db)) % 3329;
      mdl_a[aa] = ta[15:0];
      mdl_b[ab] = tb[15:0];
    end
  endtask

  task automatic read_all();
    bus_if.set = 1'b1;
    bus_if.cmd = 4'd3;
    tick();
    for (int k = 0; k < 128; k++) begin
      check($sformatf("rd_status[%0d]", k), {28'd0, bus_if.status}, 32'd3);
      check($sformatf("rd_addr[%0d]", k), {25'd0, bus_if.addr_out}, k);
      check($sformatf("rd_a[%0d]", k), {16'd0, bus_if.data_a_out}, {16'd0, mdl_a[k]});
      check($sformatf("rd_b[%0d]", k), {16'd0, bus_if.data_b_out}, {16'd0, mdl_b[k]});
      got_a[k] = bus_if.data_a_out;
      got_b[k] = bus_if.data_b_out;
      tick();
    end
    check("done_status", {28'd0, bus_if.status}, 32'd4);
    check("done_addr", {25'd0, bus_if.addr_out}, 32'd0);
    check("done_a", {16'd0, bus_if.data_a_out}, 32'd0);
    check("done_b", {16'd0, bus_if.data_b_out}, 32'd0);
    tick();
    check("done_hold", {28'd0, bus_if.status}, 32'd4);
    to_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, 4'd0, 7'd0, 16'd0, 7'd0, 16'd0);
    mode = 4'd0;
    #3 reset = 1'b0;
    #1;
    check("rst_status", {28'd0, bus_if.status}, 32'd0);
    check("rst_addr", {25'd0, bus_if.addr_out}, 32'd0);
    check("rst_a", {16'd0, bus_if.data_a_out}, 32'd0);
    check("rst_b", {16'd0, bus_if.data_b_out}, 32'd0);
    tick();
    reset = 1'b1;

    // set=0 ignores commands
    drive(1'b0, 4'd1, 7'd0, 16'd0, 7'd0, 16'd0);
    tick();
    check("set0_idle", {28'd0, bus_if.status}, 32'd0);

    // full load i+5 / i+7
    enter(4'd1);
    for (int i = 0; i < 128; i++) write_cycle(7'(i), 16'(i + 5), 7'(i), 16'(i + 7));
    to_idle();
    read_all();
    check("load_hand_a100", {16'd0, got_a[100]}, 32'd105);
    check("load_hand_b127", {16'd0, got_b[127]}, 32'd134);

    // direct LOAD->ACC passes through IDLE, then +1 everywhere
    enter(4'd1);
    bus_if.cmd = 4'd2;
    tick();
    check("direct_idle", {28'd0, bus_if.status}, 32'd0);
    tick();
    check("direct_acc", {28'd0, bus_if.status}, 32'd2);
    mode = 4'd2;
    for (int i = 0; i < 128; i++) write_cycle(7'(i), 16'd1, 7'(i), 16'd1);
    to_idle();
    read_all();
    check("acc_hand_a0", {16'd0, got_a[0]}, 32'd6);
    check("acc_hand_b127", {16'd0, got_b[127]}, 32'd135);

    // wrap, back-to-back, last-wins, independent addresses
    enter(4'd1);
    write_cycle(7'd5, 16'd3328, 7'd5, 16'd3000);
    write_cycle(7'd9, 16'd10, 7'd9, 16'd100);
    write_cycle(7'd7, 16'd111, 7'd7, 16'd222);
    write_cycle(7'd7, 16'd333, 7'd7, 16'd444);
    write_cycle(7'd12, 16'd50, 7'd13, 16'd60);
    to_idle();
    enter(4'd2);
    write_cycle(7'd5, 16'd3, 7'd5, 16'd400);
    write_cycle(7'd9, 16'd4, 7'd9, 16'd1);
    write_cycle(7'd9, 16'd5, 7'd9, 16'd2);
    to_idle();
    read_all();
    check("wrap_a5", {16'd0, got_a[5]}, 32'd2);
    check("wrap_b5", {16'd0, got_b[5]}, 32'd71);
    check("b2b_a9", {16'd0, got_a[9]}, 32'd19);
    check("b2b_b9", {16'd0, got_b[9]}, 32'd103);
    check("lastwin_a7", {16'd0, got_a[7]}, 32'd333);
    check("lastwin_b7", {16'd0, got_b[7]}, 32'd444);
    check("split_a12", {16'd0, got_a[12]}, 32'd50);
    check("split_b13", {16'd0, got_b[13]}, 32'd60);

    // 3328+3328 and the exact-q boundary
    enter(4'd1);
    write_cycle(7'd5, 16'd3328, 7'd5, 16'd3328);
    to_idle();
    enter(4'd2);
    write_cycle(7'd5, 16'd3328, 7'd5, 16'd1);
    to_idle();
    read_all();
    check("wrap2_a5", {16'd0, got_a[5]}, 32'd3327);
    check("wrapq_b5", {16'd0, got_b[5]}, 32'd0);

    // out-of-range commands act as IDLE
    drive(1'b1, 4'd13, 7'd0, 16'd0, 7'd0, 16'd0);
    tick();
    check("cmd13_idle", {28'd0, bus_if.status}, 32'd0);
    bus_if.cmd = 4'd5;
    tick();
    check("cmd5_idle", {28'd0, bus_if.status}, 32'd0);
    enter(4'd1);
    bus_if.cmd = 4'd9;
    tick();
    check("cmd9_exit", {28'd0, bus_if.status}, 32'd0);

    // set=0 during LOAD: back to IDLE, no further writes
    enter(4'd1);
    write_cycle(7'd20, 16'd999, 7'd20, 16'd888);
    drive(1'b0, 4'd1, 7'd21, 16'd777, 7'd21, 16'd777);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("set0_abort", {28'd0, bus_if.status}, 32'd0);
    end
    to_idle();

    // READ aborted by a command change
    bus_if.cmd = 4'd3;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("rdab_addr_pre", {25'd0, bus_if.addr_out}, 32'd4);
    bus_if.cmd = 4'd0;
    tick();
    check("rdab_status", {28'd0, bus_if.status}, 32'd0);
    check("rdab_addr", {25'd0, bus_if.addr_out}, 32'd0);
    check("rdab_a", {16'd0, bus_if.data_a_out}, 32'd0);

    // reset asserted mid-READ clears outputs at once, banks intact
    bus_if.cmd = 4'd3;
    tick();
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b0;
    #1;
    check("rstrd_status", {28'd0, bus_if.status}, 32'd0);
    check("rstrd_addr", {25'd0, bus_if.addr_out}, 32'd0);
    check("rstrd_a", {16'd0, bus_if.data_a_out}, 32'd0);
    check("rstrd_b", {16'd0, bus_if.data_b_out}, 32'd0);
    tick();
    bus_if.cmd = 4'd0;
    reset = 1'b1;
    tick();
    check("rstrd_idle", {28'd0, bus_if.status}, 32'd0);
    read_all();
    check("keep_a20", {16'd0, got_a[20]}, 32'd999);
    check("keep_b20", {16'd0, got_b[20]}, 32'd888);
    check("keep_a21", {16'd0, got_a[21]}, 32'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator.md
# accumulator

Two-bank polynomial coefficient accumulator for the Kyber datapath. It holds two 128-entry × 16-bit coefficient banks (A and B) and loads them from a producer. It adds further coefficient streams into the banks modulo q = 3329, then streams both banks back out in address order. A command/status pair handshakes with the controlling FSM or testbench.

## Interface
- No parameters; fixed constants: N = 128 entries, W = 16 bits, Q = 3329.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- set  in  1  block enable; when 0, commands are ignored and the FSM is held in IDLE.
- cmd  in  4  command: 0 IDLE, 1 LOAD, 2 ACCUMULATE, 3 READ; 4–15 are treated as 0.
- addr_a  in  7  bank-A write address.
- addr_b  in  7  bank-B write address.
- data_a  in  16  bank-A write data.
- data_b  in  16  bank-B write data.
- addr_out  out  7  address of the coefficients currently presented in READ.
- data_a_out  out  16  bank-A coefficient at addr_out.
- data_b_out  out  16  bank-B coefficient at addr_out.
- status  out  4  registered state code: 0 IDLE, 1 LOAD, 2 ACC, 3 READ, 4 DONE.

## Operation
- FSM states: IDLE, LOAD, ACC, READ, DONE. status always equals the current state code.
- IDLE, when set=1:
  - cmd=1 → LOAD.
  - cmd=2 → ACC.
  - cmd=3 → READ with read counter k=0.
  - Otherwise stay in IDLE.
- LOAD: every cycle with set=1 and cmd=1, write A[addr_a] ← data_a and B[addr_b] ← data_b.
  - Repeated writes to the same address are legal; the last one wins.
  - cmd≠1 → IDLE; no write occurs in that cycle.
- ACC: every cycle with set=1 and cmd=2, update A[addr_a] ← red(A[addr_a] + data_a) and B[addr_b] ← red(B[addr_b] + data_b).
  - cmd≠2 → IDLE; no update occurs in that cycle.
- red(s): s is the 17-bit sum. Result is s − 3329 if s ≥ 3329, else s, truncated to 16 bits.
  - This is exact mod 3329 when both operands are < 3329. For other operands the result is defined by the formula but is not a full modular reduction.
- READ: presents entry k on each cycle, for k = 0..127, then → DONE.
  - cmd leaving 3 mid-stream → IDLE immediately; the stream is aborted.
- DONE: hold until cmd≠3, then → IDLE.
- set=0 in any state → IDLE on the next edge. No writes occur, and bank contents are retained.
- Bank contents are not cleared by reset. After power-up they are undefined until loaded.
- A direct command change (e.g. 1→2) always passes through one IDLE cycle.

## Timing
- Reset asserted (low), asynchronously: status=0, addr_out=0, data_a_out=0, data_b_out=0, k=0.
  - Any in-flight write or read is discarded.
  - The banks are untouched, except that a write coincident with reset assertion is suppressed.
- Command acceptance: cmd is sampled at edge n in IDLE; status shows the new state after edge n.
- LOAD/ACC writes: inputs are sampled on the same edge where status is 1 or 2 and cmd matches. The new value is visible to the next read-modify-write on the following cycle.
- Back-to-back ACC hits to the same address on consecutive cycles must accumulate both hits (forward the pending result).
- READ output timing:
  - On the edge that enters READ, addr_out=0, data_a_out=A[0] and data_b_out=B[0] appear together with status=3.
  - Each following edge advances all three outputs together by one entry.
  - The edge after addr_out=127 sets status=4 and returns all data outputs to 0.
- Outputs are 0 in every state except READ.
- Latency: LOAD/ACC take effect 1 cycle after sampling. A full READ occupies 128 cycles with status=3.

## Test plan
- Reset, then LOAD: hold reset low 1 cycle, set=1, cmd=1, drive addr=i, data_a=i+5, data_b=i+7 for i=0..127, then cmd=0. Next, cmd=3 → status reads 1 during the load, then 0, then 3; the READ stream shows addr_out=i, data_a_out=i+5, data_b_out=i+7, followed by status=4.
- ACC: after the load above, cmd=2 with data_a=data_b=1 for all i, then READ → data_a_out=i+6, data_b_out=i+8.
- Modular wrap: load A[5]=3328, accumulate data_a=3 → A[5]=2; accumulate 3328+3328 → 3327.
- Back-to-back same address: two ACC cycles to A[9]=10 with data_a=4 and 5 → A[9]=19.
- Abort and enable: set=0 during LOAD → status 0 next cycle and no further writes; reset low during READ → status=0 and all outputs 0 immediately, with bank contents intact on the next READ.
